// File: rtl/reg4_arb_pkg.sv
// reg4_arb_pkg
// Shared definitions for the four-register write arbiter:
//   - state_t : arbiter FSM states (IDLE, GRANT, WRITE)
//   - DATA_W, NUM_REGS, ADDR_W : bank geometry
//   - rr_pick : round-robin winner search over a request vector
package reg4_arb_pkg;

    localparam int DATA_W   = 4;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    // Widest requester vector the pick function handles.
    localparam int MAX_REQ  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Returns the first requester with its bit set, searching upward from
    // ptr+1 and wrapping at num_req. With no request the result is ptr;
    // callers only use it when at least one bit is set.
    function automatic logic [1:0] rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                           input logic [1:0]         ptr,
                                           input int                 num_req);
        logic [1:0] pick;
        logic       found;
        int         idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (!found && i <= num_req) begin
                idx = (int'(ptr) + i) % num_req;
                if (req_vec[idx]) begin
                    pick  = 2'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/reg4_en.sv
// reg4_en
// DATA_W-bit storage register with load enable, cleared by reset.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous reset, active low
//   en  : load d on the next rising edge
//   d   : load data
//   q   : stored value
module reg4_en
    import reg4_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/reg4_bank_arbiter.sv
// reg4_bank_arbiter
// Round-robin write arbiter in front of a bank of NUM_REGS registers.
// One requester is granted at a time; its address/data are staged, exactly
// one register is written, and a one-cycle done pulse goes to the winner.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low
//   lock  : (only with REG4_ARB_LOCK_EN) keep the grant for back-to-back writes
//   req   : per-requester write request (level)
//   addr  : per-requester target register, requester i on [i*ADDR_W +: ADDR_W]
//   wdata : per-requester write data, requester i on [i*DATA_W +: DATA_W]
//   gnt   : one-hot grant (registered)
//   done  : one-cycle write-complete pulse to the winner (registered)
//   busy  : FSM is not in IDLE
//   q     : bank contents, register k on [k*DATA_W +: DATA_W]
// Build option: define REG4_ARB_LOCK_EN to add the lock input.
module reg4_bank_arbiter
    import reg4_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef REG4_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          lock,
`endif
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic                        busy,
    output logic [NUM_REGS*DATA_W-1:0]  q
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    state_t              state_reg;
    logic [NUM_REQ-1:0]  gnt_reg;
    logic [NUM_REQ-1:0]  done_reg;
    logic [1:0]          ptr_reg;
    logic [1:0]          win_reg;
    logic [ADDR_W-1:0]   stage_addr_reg;
    logic [DATA_W-1:0]   stage_data_reg;
    logic [NUM_REGS-1:0] wr_en;
    logic [1:0]          pick;
    logic                hold;

    assign pick = rr_pick(MAX_REQ'(req), ptr_reg, NUM_REQ);

    // hold: the winner keeps the bus after its write and skips arbitration.
`ifdef REG4_ARB_LOCK_EN
    assign hold = lock[win_reg] && req[win_reg];
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            gnt_reg        <= '0;
            done_reg       <= '0;
            ptr_reg        <= 2'(NUM_REQ - 1);  // requester 0 wins first
            win_reg        <= '0;
            stage_addr_reg <= '0;
            stage_data_reg <= '0;
        end else begin
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        win_reg   <= pick;
                        gnt_reg   <= ONE << pick;
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    if (req[win_reg]) begin
                        stage_addr_reg <= addr[win_reg*ADDR_W +: ADDR_W];
                        stage_data_reg <= wdata[win_reg*DATA_W +: DATA_W];
                        state_reg      <= WRITE;
                    end else begin
                        // Abort: winner withdrew, pointer left untouched.
                        gnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                WRITE: begin
                    done_reg <= ONE << win_reg;
                    if (hold) begin
                        state_reg <= GRANT;
                    end else begin
                        gnt_reg   <= '0;
                        ptr_reg   <= win_reg;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    gnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Register bank: the staged address selects a single register in WRITE.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bank
            assign wr_en[gi] = (state_reg == WRITE) && (stage_addr_reg == ADDR_W'(gi));
            reg4_en u_reg (
                .clk (clk),
                .rst (rst),
                .en  (wr_en[gi]),
                .d   (stage_data_reg),
                .q   (q[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign gnt  = gnt_reg;
    assign done = done_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_reg4_bank_arbiter.sv
// tb_reg4_bank_arbiter
// Directed bench for reg4_bank_arbiter (NUM_REQ = 3). A table of complete
// transactions is applied first, then hand-written sequences cover abort,
// reset in the middle of a write, and (with REG4_ARB_LOCK_EN) locked writes.
module tb_reg4_bank_arbiter;
    import reg4_arb_pkg::*;

    localparam int NR = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR*ADDR_W-1:0] addr = '0;
    logic [NR*DATA_W-1:0] wdata = '0;
`ifdef REG4_ARB_LOCK_EN
    logic [NR-1:0] lock = '0;
`endif
    logic [NR-1:0] gnt;
    logic [NR-1:0] done;
    logic          busy;
    logic [NUM_REGS*DATA_W-1:0] q;

    int n_checks = 0;
    int n_fail   = 0;

    reg4_bank_arbiter #(.NUM_REQ(NR)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef REG4_ARB_LOCK_EN
        .lock  (lock),
`endif
        .req   (req),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .q     (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [5:0]  addr;
        logic [11:0] wdata;
        logic [2:0]  gnt;
        logic [15:0] q;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant must never have more than one bit set.
    always @(negedge clk) begin
        if (rst) begin
            n_checks++;
            if ($countones(gnt) > 1) begin
                n_fail++;
                $display("FAIL gnt_onehot: got %b, expected at most one bit", gnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] prev_q;

    initial begin
        // addr bus = {a2,a1,a0}, wdata bus = {d2,d1,d0}; q = {r3,r2,r1,r0}
        vecs[0] = '{3'b111, 6'b100100, 12'hF51, 3'b001, 16'h0001};
        vecs[1] = '{3'b111, 6'b100100, 12'hF51, 3'b010, 16'h0051};
        vecs[2] = '{3'b111, 6'b100100, 12'hF51, 3'b100, 16'h0F51};
        vecs[3] = '{3'b111, 6'b100100, 12'hF51, 3'b001, 16'h0F51};
        vecs[4] = '{3'b010, 6'b001000, 12'h0A0, 3'b010, 16'h0A51};
        vecs[5] = '{3'b001, 6'b000011, 12'h009, 3'b001, 16'h9A51};
        vecs[6] = '{3'b010, 6'b001100, 12'h060, 3'b010, 16'h6A51};

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",  16'(gnt),  16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_q",    q,         16'h0);
        rst = 1'b1;
        prev_q = 16'h0;

        // ---------------- table of full transactions ----------------
        for (int i = 0; i < 7; i++) begin
            req   = vecs[i].req;
            addr  = vecs[i].addr;
            wdata = vecs[i].wdata;
            step();
            chk($sformatf("v%0d_gnt", i),  16'(gnt),  16'(vecs[i].gnt));
            chk($sformatf("v%0d_done0", i), 16'(done), 16'h0);
            chk($sformatf("v%0d_busy", i), 16'(busy), 16'h1);
            step();
            chk($sformatf("v%0d_q_staged", i), q, prev_q);
            chk($sformatf("v%0d_gnt_hold", i), 16'(gnt), 16'(vecs[i].gnt));
            step();
            chk($sformatf("v%0d_done", i), 16'(done), 16'(vecs[i].gnt));
            chk($sformatf("v%0d_q", i),    q,         vecs[i].q);
            chk($sformatf("v%0d_gnt_clr", i), 16'(gnt), 16'h0);
            chk($sformatf("v%0d_idle", i), 16'(busy), 16'h0);
            prev_q = vecs[i].q;
            $display("txn %0d: req=%b gnt=%b done=%b q=%h", i, vecs[i].req, vecs[i].gnt, done, q);
        end

        // ---------------- abort by requester 2 (ptr stays 1) ----------------
        req = 3'b100; addr = 6'b000000; wdata = 12'hE00;
        step();
        chk("abort_gnt", 16'(gnt), 16'h4);
        req = 3'b000;
        step();
        chk("abort_gnt_clr", 16'(gnt), 16'h0);
        chk("abort_busy", 16'(busy), 16'h0);
        step();
        chk("abort_done", 16'(done), 16'h0);
        chk("abort_q", q, 16'h6A51);
        $display("txn abort: req=100 gnt=%b done=%b q=%h", gnt, done, q);

        // ptr still 1: with 1 and 2 requesting, 2 must win.
        req = 3'b110; addr = 6'b100100; wdata = 12'h351;
        step();
        chk("post_abort_gnt", 16'(gnt), 16'h4);
        step();
        step();
        chk("post_abort_done", 16'(done), 16'h4);
        chk("post_abort_q", q, 16'h6351);
        $display("txn post-abort: req=110 gnt=100 done=%b q=%h", done, q);

        // ---------------- reset in the middle of WRITE ----------------
        req = 3'b010; addr = 6'b001100; wdata = 12'h0D0;
        step();
        chk("rw_gnt", 16'(gnt), 16'h2);
        step();
        chk("rw_busy", 16'(busy), 16'h1);
        chk("rw_q_before", q, 16'h6351);
        rst = 1'b0;
        #1;
        chk("rw_q_clr",    q,         16'h0);
        chk("rw_gnt_clr",  16'(gnt),  16'h0);
        chk("rw_done_clr", 16'(done), 16'h0);
        chk("rw_busy_clr", 16'(busy), 16'h0);
        req = 3'b000;
        step();
        step();
        chk("rw_q_held", q, 16'h0);
        chk("rw_done_none", 16'(done), 16'h0);
        rst = 1'b1;
        $display("txn reset-mid-write: gnt=%b done=%b q=%h", gnt, done, q);

        // ---------------- after reset: 0 first, then 1 ----------------
        req = 3'b011; addr = 6'b100100; wdata = 12'hF51;
`ifdef REG4_ARB_LOCK_EN
        lock = 3'b001;
        step();
        chk("lk_gnt", 16'(gnt), 16'h1);
        step();
        step();
        chk("lk_done1", 16'(done), 16'h1);
        chk("lk_gnt_kept", 16'(gnt), 16'h1);
        chk("lk_busy", 16'(busy), 16'h1);
        chk("lk_q1", q, 16'h0001);
        lock = 3'b000;
        wdata = 12'hF52;
        step();
        chk("lk_done_gap", 16'(done), 16'h0);
        step();
        chk("lk_done2", 16'(done), 16'h1);
        chk("lk_q2", q, 16'h0002);
        chk("lk_gnt_clr", 16'(gnt), 16'h0);
        step();
        chk("lk_next_gnt", 16'(gnt), 16'h2);
        step();
        step();
        chk("lk_next_done", 16'(done), 16'h2);
        chk("lk_next_q", q, 16'h0052);
        $display("txn lock: req=011 lock=001 then 000 done=%b q=%h", done, q);
`else
        step();
        chk("pr_gnt0", 16'(gnt), 16'h1);
        step();
        step();
        chk("pr_done0", 16'(done), 16'h1);
        chk("pr_q0", q, 16'h0001);
        step();
        chk("pr_gnt1", 16'(gnt), 16'h2);
        chk("pr_done_pulse", 16'(done), 16'h0);
        step();
        step();
        chk("pr_done1", 16'(done), 16'h2);
        chk("pr_q1", q, 16'h0051);
        $display("txn post-reset: req=011 gnt 001 then 010 q=%h", q);
`endif
        req = 3'b000;
        step();
        chk("end_done", 16'(done), 16'h0);
        chk("end_busy", 16'(busy), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
